// File: rtl/multi_slave_arbiter.sv
// Arbitrates NUM_SLV pixel sources onto one registered beat bus feeding the shared
// processing FIFO, with burst-limited sharing, FIFO throttling and a completion drain.
module multi_slave_arbiter #(
  parameter int DW        = 32,
  parameter int NUM_SLV   = 4,
  parameter int MODE_W    = 2,
  parameter int ARB_MODE  = 1,
  parameter int MAX_BURST = 16,
  parameter int END_WAIT  = 2,
  localparam int SW       = (NUM_SLV > 2) ? $clog2(NUM_SLV) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SLV*MODE_W-1:0] slv_mode,
  input  logic [NUM_SLV-1:0]        slv_data_valid,
  input  logic [NUM_SLV*DW-1:0]     slv_data,
  input  logic [NUM_SLV-1:0]        slv_proc_valid,
  output logic [NUM_SLV-1:0]        slv_ready,
  output logic [MODE_W-1:0]         slvx_mode,
  output logic                      slvx_data_valid,
  output logic [DW-1:0]             slvx_data,
  output logic                      slvx_proc_val,
  output logic [SW-1:0]             data_source,
  input  logic                      fifo_threshold,
  input  logic                      fifo_empty,
  input  logic                      proc_cmplt,
  output logic                      mstr_cmplt
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int EW = (END_WAIT > 0) ? $clog2(END_WAIT + 1) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     rr_ptr;
  logic [BW-1:0]     beat_cnt;
  logic [EW-1:0]     end_cnt;
  logic [NUM_SLV-1:0] req;
  logic [MODE_W-1:0] mode_arr [NUM_SLV];
  logic [DW-1:0]     data_arr [NUM_SLV];
  logic [SW-1:0]     sel;
  logic [SW-1:0]     rr_nxt;
  logic              any_req;
  logic              req_g;
  logic              ready_g;
  logic              hs;
  logic              burst_end;

  for (genvar i = 0; i < NUM_SLV; i++) begin : g_unpack
    assign mode_arr[i] = slv_mode[i*MODE_W +: MODE_W];
    assign data_arr[i] = slv_data[i*DW +: DW];
    assign req[i]      = |slv_mode[i*MODE_W +: MODE_W];
  end

  // Scanning from the highest candidate down leaves the first match in priority order.
  always_comb begin
    int idx;
    sel = '0;
    idx = 0;
    if (ARB_MODE == 0) begin
      for (int i = NUM_SLV - 1; i >= 0; i--)
        if (req[SW'(i)]) sel = SW'(i);
    end else begin
      for (int k = NUM_SLV - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_SLV) idx = idx - NUM_SLV;
        if (req[SW'(idx)]) sel = SW'(idx);
      end
    end
  end

  assign any_req   = |req;
  assign rr_nxt    = (sel == SW'(NUM_SLV - 1)) ? '0 : sel + SW'(1);
  assign req_g     = req[data_source];
  assign ready_g   = (state == GRANT) && !fifo_threshold && !proc_cmplt && req_g;
  assign hs        = ready_g && slv_data_valid[data_source];
  assign burst_end = hs && (beat_cnt == BW'(MAX_BURST - 1));
  assign mstr_cmplt = (state == DONE);

  always_comb begin
    state_nxt = state;
    slv_ready = '0;
    case (state)
      IDLE: begin
        if (proc_cmplt)   state_nxt = DRAIN;
        else if (any_req) state_nxt = GRANT;
      end
      GRANT: begin
        if (ready_g) slv_ready[data_source] = 1'b1;
        if (proc_cmplt)                state_nxt = DRAIN;
        else if (burst_end || !req_g)  state_nxt = IDLE;
      end
      DRAIN: begin
        if (end_cnt == '0 && fifo_empty) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      data_source     <= '0;
      rr_ptr          <= '0;
      beat_cnt        <= '0;
      end_cnt         <= '0;
      slvx_data_valid <= 1'b0;
      slvx_data       <= '0;
      slvx_mode       <= '0;
      slvx_proc_val   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          slvx_data_valid <= 1'b0;
          if (proc_cmplt) begin
            end_cnt       <= EW'(END_WAIT);
            slvx_mode     <= '0;
            slvx_proc_val <= 1'b0;
          end else if (any_req) begin
            data_source <= sel;
            beat_cnt    <= '0;
            rr_ptr      <= rr_nxt;
          end
        end
        GRANT: begin
          if (hs) begin
            slvx_data_valid <= 1'b1;
            slvx_data       <= data_arr[data_source];
            slvx_mode       <= mode_arr[data_source];
            slvx_proc_val   <= slv_proc_valid[data_source];
            beat_cnt        <= beat_cnt + BW'(1);
          end else begin
            slvx_data_valid <= 1'b0;
            if (proc_cmplt) begin
              end_cnt       <= EW'(END_WAIT);
              slvx_mode     <= '0;
              slvx_proc_val <= 1'b0;
            end
          end
        end
        DRAIN: begin
          slvx_data_valid <= 1'b0;
          if (end_cnt != '0) end_cnt <= end_cnt - EW'(1);
        end
        DONE: begin
          slvx_data_valid <= 1'b0;
          data_source     <= '0;
          rr_ptr          <= '0;
        end
        default: slvx_data_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multi_slave_arbiter.sv
// Randomized scoreboard bench for multi_slave_arbiter: a cycle-level reference model
// predicts readies, completion and every accepted beat; a monitor checks the beat bus.
module tb_multi_slave_arbiter;

  localparam int DW = 32;
  localparam int N = 4;
  localparam int MW = 2;
  localparam int MAXB = 4;
  localparam int EWAIT = 2;
  localparam int NCYC = 2500;

  logic clk = 1'b0;
  logic rst;
  logic [N*MW-1:0] slv_mode;
  logic [N-1:0] slv_data_valid;
  logic [N*DW-1:0] slv_data;
  logic [N-1:0] slv_proc_valid;
  logic [N-1:0] slv_ready;
  logic [MW-1:0] slvx_mode;
  logic slvx_data_valid;
  logic [DW-1:0] slvx_data;
  logic slvx_proc_val;
  logic [1:0] data_source;
  logic fifo_threshold;
  logic fifo_empty;
  logic proc_cmplt;
  logic mstr_cmplt;

  multi_slave_arbiter #(
    .DW(DW), .NUM_SLV(N), .MODE_W(MW), .ARB_MODE(1), .MAX_BURST(MAXB), .END_WAIT(EWAIT)
  ) dut (
    .clk(clk), .rst(rst), .slv_mode(slv_mode), .slv_data_valid(slv_data_valid),
    .slv_data(slv_data), .slv_proc_valid(slv_proc_valid), .slv_ready(slv_ready),
    .slvx_mode(slvx_mode), .slvx_data_valid(slvx_data_valid), .slvx_data(slvx_data),
    .slvx_proc_val(slvx_proc_val), .data_source(data_source),
    .fifo_threshold(fifo_threshold), .fifo_empty(fifo_empty),
    .proc_cmplt(proc_cmplt), .mstr_cmplt(mstr_cmplt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    logic [DW-1:0] data;
    int src;
  } beat_t;

  beat_t sb_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int modes[N];

  // Reference model: phase 0 idle, 1 owning a source, 2 draining, 3 completion pulse.
  int phase, owner, beats, rr, wait_cnt, src_reg, last_mode, last_pv;

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    phase = 0; owner = 0; beats = 0; rr = 0; wait_cnt = 0;
    src_reg = 0; last_mode = 0; last_pv = 0;
  endtask

  task automatic apply_stimulus(input int c);
    rst = (c < 3 || c == 700 || c == 1400);
    for (int i = 0; i < N; i++) begin
      if (c < 40) modes[i] = (i == 2) ? 1 : 0;
      else if (c > NCYC - 15) modes[i] = 0;
      else if ($urandom_range(0, 15) == 0) modes[i] = $urandom_range(0, 3);
      slv_mode[i*MW +: MW] = MW'(modes[i]);
      slv_data[i*DW +: DW] = (c < 40) ? DW'(32'hA0 + c) : DW'($urandom);
      slv_data_valid[i] = (c < 40) ? 1'b1 : ($urandom_range(0, 3) != 0);
      slv_proc_valid[i] = 1'($urandom_range(0, 1));
    end
    fifo_threshold = (c >= 40) && ($urandom_range(0, 7) == 0);
    proc_cmplt = (c >= 40) && (c <= NCYC - 15) && ($urandom_range(0, 49) == 0);
    fifo_empty = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    r = '0;
    if (phase == 1 && modes[owner] != 0 && !fifo_threshold && !proc_cmplt) r[owner] = 1'b1;
    return r;
  endfunction

  task automatic check_output();
    check_val("slv_ready", 64'(slv_ready), 64'(model_ready()));
    check_val("mstr_cmplt", 64'(mstr_cmplt), 64'(phase == 3));
    check_val("data_source", 64'(data_source), 64'(src_reg));
    check_val("slvx_mode", 64'(slvx_mode), 64'(last_mode));
    check_val("slvx_proc_val", 64'(slvx_proc_val), 64'(last_pv));
  endtask

  task automatic enter_drain();
    phase = 2; wait_cnt = EWAIT; last_mode = 0; last_pv = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] rdy;
    int g;
    beat_t b;
    rdy = model_ready();
    if (rst) begin
      model_reset();
      return;
    end
    case (phase)
      0: begin
        g = -1;
        for (int k = 0; k < N; k++)
          if (g < 0 && modes[(rr + k) % N] != 0) g = (rr + k) % N;
        if (proc_cmplt) enter_drain();
        else if (g >= 0) begin
          phase = 1; owner = g; src_reg = g; beats = 0; rr = (g + 1) % N;
        end
      end
      1: begin
        if (proc_cmplt) enter_drain();
        else if (rdy[owner] && slv_data_valid[owner]) begin
          b.due = cyc + 1;
          b.data = slv_data[owner*DW +: DW];
          b.src = owner;
          sb_q.push_back(b);
          last_mode = modes[owner];
          last_pv = slv_proc_valid[owner];
          beats++;
          if (beats == MAXB) phase = 0;
        end else if (modes[owner] == 0) phase = 0;
      end
      2: begin
        if (wait_cnt == 0 && fifo_empty) phase = 3;
        else if (wait_cnt > 0) wait_cnt--;
      end
      default: begin
        phase = 0; src_reg = 0; rr = 0;
      end
    endcase
  endtask

  // Monitor: an expected beat must appear exactly on its due cycle, and no other beat may.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (cyc > 0) begin
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
          e = sb_q.pop_front();
          check_val("beat_valid", 64'(slvx_data_valid), 64'(1));
          check_val("beat_data", 64'(slvx_data), 64'(e.data));
          check_val("beat_src", 64'(data_source), 64'(e.src));
        end else begin
          check_val("idle_valid", 64'(slvx_data_valid), 64'(0));
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    slv_mode = '0;
    slv_data_valid = '0;
    slv_data = '0;
    slv_proc_valid = '0;
    fifo_threshold = 1'b0;
    fifo_empty = 1'b0;
    proc_cmplt = 1'b0;
    model_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc++;
      apply_stimulus(c);
      @(negedge clk);
      check_output();
      model_step();
    end
    @(posedge clk);
    #1;
    cyc++;
    @(negedge clk);
    #1;
    check_val("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
